// File: rtl/tripack.sv
// Variable-length stream packer: concatenates the low bits of up to BS lanes per cycle
// LSB-first and emits VLEN-bit words, plus a final partial word at stream end.
module tripack #(
  parameter  int unsigned VLEN = 256,
  parameter  int unsigned BSW  = 5,
  localparam int unsigned BS   = 1 << BSW,
  localparam int unsigned EW   = VLEN / BS,
  localparam int unsigned WW   = 8 - BSW + 1,
  localparam int unsigned FW   = $clog2(VLEN) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BSW:0]     in_num,
  input  logic [WW*BS-1:0] in_len,
  input  logic [EW*BS-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VLEN-1:0]  out_data,
  output logic [FW-1:0]    out_bits,
  output logic             out_last
);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e          state_q, state_d;
  logic [VLEN-1:0] acc_q, acc_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            valid_q, valid_d;
  logic [VLEN-1:0] data_q, data_d;
  logic [FW-1:0]   bits_q, bits_d;
  logic            last_q, last_d;

  logic [VLEN-1:0]   pk;
  logic [FW-1:0]     tot;
  logic [FW-1:0]     off;
  logic [WW-1:0]     len_raw;
  logic [WW-1:0]     elen;
  logic [EW-1:0]     lane;
  logic [2*VLEN-1:0] comb;
  logic [FW-1:0]     nf;
  logic              accept;

  // Lane offsets are the running (exclusive prefix) sum of effective lengths.
  always_comb begin
    pk      = '0;
    off     = '0;
    len_raw = '0;
    elen    = '0;
    lane    = '0;
    for (int i = 0; i < BS; i++) begin
      len_raw = in_len[i*WW +: WW];
      if (i < int'(in_num)) begin
        elen = (len_raw > WW'(EW)) ? WW'(EW) : len_raw;
      end else begin
        elen = '0;
      end
      lane = in_data[i*EW +: EW] & EW'((32'd1 << elen) - 32'd1);
      pk   = pk | (VLEN'(lane) << off);
      off  = off + FW'(elen);
    end
    tot = off;
  end

  assign comb     = {{VLEN{1'b0}}, acc_q} | ({{VLEN{1'b0}}, pk} << fill_q);
  assign nf       = fill_q + tot;
  assign in_ready = (state_q == StRun) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    data_d  = data_q;
    bits_d  = bits_q;
    last_d  = last_q;
    unique case (state_q)
      StRun: begin
        if (accept) begin
          if (nf >= FW'(VLEN)) begin
            valid_d = 1'b1;
            data_d  = comb[VLEN-1:0];
            bits_d  = FW'(VLEN);
            acc_d   = comb[2*VLEN-1:VLEN];
            fill_d  = nf - FW'(VLEN);
            last_d  = in_last && (nf == FW'(VLEN));
            // Residual bits past the boundary need their own closing word.
            if (in_last && (nf != FW'(VLEN))) begin
              state_d = StFlush;
            end
          end else if (in_last) begin
            valid_d = 1'b1;
            data_d  = comb[VLEN-1:0];
            bits_d  = nf;
            last_d  = 1'b1;
            acc_d   = '0;
            fill_d  = '0;
          end else begin
            valid_d = 1'b0;
            acc_d   = comb[VLEN-1:0];
            fill_d  = nf;
          end
        end else if (valid_q && out_ready) begin
          valid_d = 1'b0;
        end
      end
      StFlush: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b1;
          data_d  = acc_q;
          bits_d  = fill_q;
          last_d  = 1'b1;
          acc_d   = '0;
          fill_d  = '0;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StRun;
      acc_q   <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      bits_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      bits_q  <= bits_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_bits  = bits_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_tripack.sv
// Directed bench for tripack: single-vector table plus hand-written multi-cycle sequences
// (word-boundary flush, backpressure hold, chained partials, reset during flush).
module tb_tripack;

  logic         clk;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   in_num;
  logic [127:0] in_len;
  logic [255:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic [8:0]   out_bits;
  logic         out_last;

  int total;
  int bad;

  tripack #(
    .VLEN(256),
    .BSW (5)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_num   (in_num),
    .in_len   (in_len),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_bits (out_bits),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rstn && in_valid) begin
      assert (in_num <= 6'd32) else $error("illegal in_num %0d", in_num);
    end
  end

  typedef struct {
    logic [5:0]   num;
    logic [127:0] len;
    logic [255:0] data;
    logic         last;
    logic [8:0]   ebits;
    logic [255:0] edata;
    logic         elast;
  } vec_t;

  localparam int NV = 6;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_num   = v.num;
    in_len   = v.len;
    in_data  = v.data;
    in_last  = v.last;
  endtask

  task automatic chk_word(input string name, input logic [8:0] b, input logic [255:0] d,
                          input logic l);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_bits"}, out_bits, b);
    chk({name, "_data"}, out_data, d);
    chk({name, "_last"}, out_last, l);
  endtask

  // Sequence used for the boundary-crossing stream: 10 vectors of 27 bits each.
  vec_t         t3;
  logic [255:0] t3data;
  int           ln[9];
  bit           stream[$];
  logic [255:0] w1;
  logic [255:0] w2;
  vec_t         tmp;

  initial begin
    total = 0;
    bad   = 0;

    tbl[0] = '{6'd7, 128'h5322364, {32{8'hFF}}, 1'b1, 9'd25, 256'h1FFFFFF, 1'b1};
    tbl[1] = '{6'd7, 128'h5322364, {32{8'h01}}, 1'b1, 9'd25, 256'h12A411, 1'b1};
    tbl[2] = '{6'd2, {{30{4'hF}}, 4'hC, 4'h3}, {32{8'hFF}}, 1'b1, 9'd11, 256'h7FF, 1'b1};
    tbl[3] = '{6'd0, {{30{4'hF}}, 4'hC, 4'h3}, {32{8'hFF}}, 1'b1, 9'd0, 256'h0, 1'b1};
    tbl[4] = '{6'd3, 128'h321, 256'hFBFFFE, 1'b1, 9'd6, 256'h1E, 1'b1};
    tbl[5] = '{6'd32, {32{4'h8}}, {8{32'hDEADBEEF}}, 1'b1, 9'd256, {8{32'hDEADBEEF}}, 1'b1};

    t3data = 256'hC39C3E6B17D2845AF1;
    t3     = '{6'd9, 128'h433342332, t3data, 1'b0, 9'd0, 256'h0, 1'b0};
    ln     = '{2, 3, 3, 2, 4, 3, 3, 3, 4};
    stream = {};
    for (int k = 0; k < 10; k++) begin
      for (int l = 0; l < 9; l++) begin
        for (int b = 0; b < ln[l]; b++) begin
          stream.push_back(t3data[l*8+b]);
        end
      end
    end
    w1 = '0;
    w2 = '0;
    for (int j = 0; j < 256; j++) w1[j] = stream[j];
    for (int j = 0; j < 14; j++) w2[j] = stream[256+j];

    rstn      = 1'b1;
    in_valid  = 1'b0;
    in_num    = '0;
    in_len    = '0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2 rstn = 1'b0;
    #2;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_bits", out_bits, 9'd0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_data", out_data, 256'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1'b1);

    // Single-vector table: each vector is a complete stream.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1 chk($sformatf("tbl%0d_in_ready", i), in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk_word($sformatf("tbl%0d", i), tbl[i].ebits, tbl[i].edata, tbl[i].elast);
    end
    @(negedge clk);
    #1 chk("idle_valid", out_valid, 1'b0);

    // Ten 27-bit vectors: first nine accumulate, the last crosses the word boundary.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      t3.last = (k == 9);
      drive(t3);
      #1 chk($sformatf("t3_in_ready%0d", k), in_ready, 1'b1);
      if (k > 0) chk($sformatf("t3_noword%0d", k), out_valid, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk_word("t3_w1", 9'd256, w1, 1'b0);
    chk("t3_bubble", in_ready, 1'b0);
    @(negedge clk);
    #1 chk_word("t3_w2", 9'd14, w2, 1'b1);
    chk("t3_ready_back", in_ready, 1'b1);

    // Backpressure: pending word must hold while a second vector waits.
    @(negedge clk);
    out_ready = 1'b0;
    drive(tbl[0]);
    #1 chk("bp_in_ready0", in_ready, 1'b1);
    @(negedge clk);
    drive(tbl[1]);
    for (int c = 0; c < 5; c++) begin
      #1 chk_word($sformatf("bp_hold%0d", c), 9'd25, 256'h1FFFFFF, 1'b1);
      chk($sformatf("bp_in_ready%0d", c), in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_release", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk_word("bp_next", 9'd25, 256'h12A411, 1'b1);

    // Partial residual carried into a terminating vector.
    @(negedge clk);
    tmp = '{6'd1, 128'h5, 256'h15, 1'b0, 9'd0, 256'h0, 1'b0};
    drive(tmp);
    @(negedge clk);
    tmp = '{6'd1, 128'h3, 256'h06, 1'b1, 9'd0, 256'h0, 1'b0};
    drive(tmp);
    #1 chk("chain_noword", out_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk_word("chain", 9'd8, 256'hD5, 1'b1);

    // Reset asserted while a flush is pending under backpressure.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      t3.last = (k == 9);
      drive(t3);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1 chk_word("fl_w1", 9'd256, w1, 1'b0);
    chk("fl_in_ready", in_ready, 1'b0);
    @(negedge clk);
    #1 chk("fl_hold_bits", out_bits, 9'd256);
    #1 rstn = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_bits", out_bits, 9'd0);
    chk("arst_last", out_last, 1'b0);
    @(negedge clk);
    rstn      = 1'b1;
    out_ready = 1'b1;
    #1 chk("arst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    drive(tbl[0]);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk_word("arst_t1", 9'd25, 256'h1FFFFFF, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
